// File: rtl/jload_ctrl.sv
// Boot/load sequencer between the J serial word port and the CPU core.
// Streams 2*DEPTH words into data then instruction memory, highest address first.
//
// Ports:
//   clk, rst         clock (rising edge), async active-low reset
//   Jen, Jin         load enable and load word (one word per cycle while Jen=1)
//   Jout             Jin delayed by one cycle, every cycle
//   dmem_we, imem_we data / instruction memory write strobes
//   mem_addr         shared write address
//   mem_wdata        shared write data
//   cpu_en           CPU clock enable (0 = frozen)
//   cpu_start        one-cycle pulse on the first RUN cycle
//   busy             high in LOAD or DONE
//   load_err         sticky: Jen dropped before the image was complete
//   load_ovf         sticky: words arrived after the image was complete
module jload_ctrl #(
    parameter int DEPTH = 512,
    parameter int AW    = 9,
    parameter int DW    = 32
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          Jen,
    input  logic [DW-1:0] Jin,
    output logic [DW-1:0] Jout,
    output logic          dmem_we,
    output logic          imem_we,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    output logic          cpu_en,
    output logic          cpu_start,
    output logic          busy,
    output logic          load_err,
    output logic          load_ovf
);

    localparam int IW = AW + 1;

    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_LOAD = 3'd1;
    localparam logic [2:0] S_DONE = 3'd2;
    localparam logic [2:0] S_RUN  = 3'd3;
    localparam logic [2:0] S_ERR  = 3'd4;

    localparam logic [IW-1:0] IDX_DEP  = IW'(DEPTH);
    localparam logic [IW-1:0] IDX_LAST = IW'(2 * DEPTH - 1);
    localparam logic [AW-1:0] ADR_TOP  = AW'(DEPTH - 1);
    localparam logic [AW-1:0] ADR_DEP  = AW'(DEPTH);

    logic [2:0]    state_q, state_d;
    logic [IW-1:0] idx_q, idx_d;
    logic          err_q, err_d;
    logic          ovf_q, ovf_d;
    logic          start_q, start_d;
    logic          dwe_q, dwe_d;
    logic          iwe_q, iwe_d;
    logic [AW-1:0] addr_q, addr_d;
    logic [DW-1:0] wdata_q, wdata_d;
    logic [DW-1:0] jout_q;

    logic          acc;
    logic [IW-1:0] widx;
    logic          dsel;
    logic [AW-1:0] off;

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        err_d   = err_q;
        ovf_d   = ovf_q;
        start_d = 1'b0;
        acc     = 1'b0;
        widx    = idx_q;
        case (state_q)
            S_IDLE, S_ERR, S_RUN: begin
                // Any Jen starts a fresh image at word 0.
                if (Jen) begin
                    state_d = S_LOAD;
                    acc     = 1'b1;
                    widx    = '0;
                    idx_d   = IW'(1);
                    err_d   = 1'b0;
                    ovf_d   = 1'b0;
                end
            end
            S_LOAD: begin
                if (Jen) begin
                    acc   = 1'b1;
                    idx_d = idx_q + IW'(1);
                    if (idx_q == IDX_LAST) begin
                        state_d = S_DONE;
                    end
                end else begin
                    state_d = S_ERR;
                    err_d   = 1'b1;
                end
            end
            S_DONE: begin
                if (Jen) begin
                    ovf_d = 1'b1;
                end else begin
                    state_d = S_RUN;
                    start_d = 1'b1;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Both halves count down from DEPTH-1; modulo-2^AW arithmetic
    // folds the instruction half back onto the same address range.
    always_comb begin
        dsel    = (widx < IDX_DEP);
        off     = widx[AW-1:0] - (dsel ? '0 : ADR_DEP);
        dwe_d   = acc & dsel;
        iwe_d   = acc & ~dsel;
        addr_d  = acc ? (ADR_TOP - off) : addr_q;
        wdata_d = acc ? Jin : wdata_q;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_IDLE;
            idx_q   <= '0;
            err_q   <= 1'b0;
            ovf_q   <= 1'b0;
            start_q <= 1'b0;
            dwe_q   <= 1'b0;
            iwe_q   <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            jout_q  <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            err_q   <= err_d;
            ovf_q   <= ovf_d;
            start_q <= start_d;
            dwe_q   <= dwe_d;
            iwe_q   <= iwe_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            jout_q  <= Jin;
        end
    end

    assign Jout      = jout_q;
    assign dmem_we   = dwe_q;
    assign imem_we   = iwe_q;
    assign mem_addr  = addr_q;
    assign mem_wdata = wdata_q;
    assign cpu_en    = (state_q == S_RUN);
    assign cpu_start = start_q;
    assign busy      = (state_q == S_LOAD) | (state_q == S_DONE);
    assign load_err  = err_q;
    assign load_ovf  = ovf_q;

endmodule

// File: tb/tb_jload_ctrl.sv
// Testbench for jload_ctrl: directed load sequences with a write scoreboard.
// Expected writes are queued at issue time; a negedge monitor pops and compares.
module tb_jload_ctrl;

    logic        clk;
    logic        rst;
    logic        Jen;
    logic [31:0] Jin;
    logic [31:0] Jout;
    logic        dmem_we;
    logic        imem_we;
    logic [8:0]  mem_addr;
    logic [31:0] mem_wdata;
    logic        cpu_en;
    logic        cpu_start;
    logic        busy;
    logic        load_err;
    logic        load_ovf;

    jload_ctrl #(.DEPTH(512), .AW(9), .DW(32)) dut (
        .clk       (clk),
        .rst       (rst),
        .Jen       (Jen),
        .Jin       (Jin),
        .Jout      (Jout),
        .dmem_we   (dmem_we),
        .imem_we   (imem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .cpu_en    (cpu_en),
        .cpu_start (cpu_start),
        .busy      (busy),
        .load_err  (load_err),
        .load_ovf  (load_ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_pass  = 0;
    int n_total = 0;

    // entry = {is_imem, addr[8:0], data[31:0]}
    logic [41:0] sb[$];
    logic [31:0] dm[512];
    logic [31:0] im[512];
    int          wr_cnt  = 0;
    logic [8:0]  last_a  = '0;
    logic        last_im = 1'b0;
    int          exp_idx = 0;

    task automatic chk(input string name, input logic [41:0] act,
                       input logic [41:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    always @(negedge clk) begin
        if (rst) begin
            if (dmem_we && imem_we) begin
                chk("both_we", 42'd1, 42'd0);
            end else if (dmem_we || imem_we) begin
                if (sb.size() == 0) begin
                    chk("unexpected_write", {imem_we, mem_addr, mem_wdata}, '0);
                end else begin
                    chk("write", {imem_we, mem_addr, mem_wdata}, sb.pop_front());
                end
                if (imem_we) im[mem_addr] = mem_wdata;
                else         dm[mem_addr] = mem_wdata;
                wr_cnt++;
                last_a  = mem_addr;
                last_im = imem_we;
            end
        end
    end

    task automatic cyc(input logic en, input logic [31:0] d);
        Jen = en;
        Jin = d;
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [31:0] d);
        logic [8:0] a;
        if (exp_idx < 1024) begin
            a = (exp_idx < 512) ? 9'(511 - exp_idx) : 9'(1023 - exp_idx);
            sb.push_back({(exp_idx >= 512), a, d});
        end
        exp_idx++;
        cyc(1'b1, d);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: timeout reached");
        $fatal(1, "timeout");
    end

    initial begin
        int w0;
        // Reset with Jen high and all-ones data.
        rst = 1'b0;
        Jen = 1'b1;
        Jin = 32'hFFFF_FFFF;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_dmem_we", 42'(dmem_we), 42'd0);
        chk("rst_imem_we", 42'(imem_we), 42'd0);
        chk("rst_addr",    42'(mem_addr), 42'd0);
        chk("rst_wdata",   42'(mem_wdata), 42'd0);
        chk("rst_jout",    42'(Jout), 42'd0);
        chk("rst_cpu_en",  42'(cpu_en), 42'd0);
        chk("rst_start",   42'(cpu_start), 42'd0);
        chk("rst_busy",    42'(busy), 42'd0);
        chk("rst_err",     42'(load_err), 42'd0);
        chk("rst_ovf",     42'(load_ovf), 42'd0);
        Jen = 1'b0;
        rst = 1'b1;
        cyc(1'b0, 32'h0);
        chk("idle_busy", 42'(busy), 42'd0);

        // Full load with Jin = word index.
        exp_idx = 0;
        for (int i = 0; i < 1024; i++) send(32'(i));
        chk("done_busy",   42'(busy), 42'd1);
        chk("done_cpu_en", 42'(cpu_en), 42'd0);
        chk("done_start",  42'(cpu_start), 42'd0);
        cyc(1'b0, 32'h1234_ABCD);
        chk("run_start",  42'(cpu_start), 42'd1);
        chk("run_cpu_en", 42'(cpu_en), 42'd1);
        chk("run_busy",   42'(busy), 42'd0);
        chk("jout_echo",  42'(Jout), 42'h1234_ABCD);
        cyc(1'b0, 32'h0);
        chk("run_start_pulse", 42'(cpu_start), 42'd0);
        chk("run_cpu_en2",     42'(cpu_en), 42'd1);
        chk("full_err", 42'(load_err), 42'd0);
        chk("full_ovf", 42'(load_ovf), 42'd0);
        chk("dm511", 42'(dm[511]), 42'd0);
        chk("dm0",   42'(dm[0]),   42'd511);
        chk("im511", 42'(im[511]), 42'd512);
        chk("im0",   42'(im[0]),   42'd1023);
        chk("full_sb_empty", 42'(sb.size()), 42'd0);

        // Reload from RUN, then drop Jen after 300 words.
        exp_idx = 0;
        send(32'hA000_0000);
        chk("reload_cpu_en", 42'(cpu_en), 42'd0);
        chk("reload_busy",   42'(busy), 42'd1);
        for (int i = 1; i < 300; i++) send(32'hA000_0000 + 32'(i));
        cyc(1'b0, 32'h0);
        chk("err_flag",   42'(load_err), 42'd1);
        chk("err_cpu_en", 42'(cpu_en), 42'd0);
        chk("err_busy",   42'(busy), 42'd0);
        w0 = wr_cnt;
        cyc(1'b0, 32'h0);
        cyc(1'b0, 32'h0);
        chk("err_no_write", 42'(wr_cnt), 42'(w0));
        chk("err_last_addr", {33'(last_im), last_a}, 42'd212);
        chk("dm212", 42'(dm[212]), 42'hA000_012B);

        // Restart and overrun: Jen high for 1030 cycles.
        exp_idx = 0;
        wr_cnt  = 0;
        send(32'hB000_0000);
        chk("restart_err_clr", 42'(load_err), 42'd0);
        for (int i = 1; i < 1030; i++) send(32'hB000_0000 + 32'(i));
        chk("ovf_flag", 42'(load_ovf), 42'd1);
        chk("ovf_busy", 42'(busy), 42'd1);
        cyc(1'b0, 32'h0);
        chk("ovf_run_start", 42'(cpu_start), 42'd1);
        chk("ovf_sticky",    42'(load_ovf), 42'd1);
        cyc(1'b0, 32'h0);
        chk("ovf_wr_cnt", 42'(wr_cnt), 42'd1024);
        chk("ovf_dm511",  42'(dm[511]), 42'hB000_0000);
        chk("ovf_im0",    42'(im[0]), 42'hB000_03FF);
        chk("ovf_sb_empty", 42'(sb.size()), 42'd0);

        // Reload from RUN, async reset at word 100.
        exp_idx = 0;
        for (int i = 0; i < 100; i++) send(32'hC000_0000 + 32'(i));
        chk("pre_rst_we",  42'(dmem_we), 42'd1);
        chk("reload_ovf_clr", 42'(load_ovf), 42'd0);
        #2;
        rst = 1'b0;
        #1;
        chk("async_we",   42'(dmem_we), 42'd0);
        chk("async_busy", 42'(busy), 42'd0);
        chk("async_addr", 42'(mem_addr), 42'd0);
        chk("async_jout", 42'(Jout), 42'd0);
        @(posedge clk);
        #1;
        sb.delete();
        Jen = 1'b0;
        rst = 1'b1;
        cyc(1'b0, 32'h0);
        chk("post_rst_busy",   42'(busy), 42'd0);
        chk("post_rst_cpu_en", 42'(cpu_en), 42'd0);
        chk("partial_dm413",   42'(dm[413]), 42'hC000_0062);
        exp_idx = 0;
        send(32'hD00D_0001);
        chk("idle_load_busy", 42'(busy), 42'd1);
        cyc(1'b0, 32'h0);
        cyc(1'b0, 32'h0);
        chk("idle_load_dm511", 42'(dm[511]), 42'hD00D_0001);
        chk("final_sb_empty",  42'(sb.size()), 42'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
